tanimoto_axis_intf: RTL and testbench
=====================================

# tanimoto_axis_intf

Parametrised AXI-Stream interface shell for the Tanimoto comparator array. It places a zero-bubble skid buffer between the S_AXIS_DATA vector stream and the core vector input. It collects ID pairs from CH_NO comparator channels through a round-robin arbiter into an output FIFO that drains to M_AXIS_ID_PAIR. It also keeps saturating vector and pair counters for host status.

## Interface
Parameters:
- BUS_WIDTH, 512, vector stream beat width.
- VEC_ID_WIDTH, 8, width of one vector ID; a pair is 2*VEC_ID_WIDTH bits.
- CH_NO, 4, number of comparator channels (>=1).
- FIFO_DEPTH, 16, output FIFO entries (power of two, >=2).
- CNT_WIDTH, 32, width of the status counters.

Ports:
- ap_clk  in  1  sole clock.
- ap_rstn  in  1  reset; asynchronous assertion, active-low.
- S_AXIS_DATA_tdata  in  BUS_WIDTH  vector beat.
- S_AXIS_DATA_tvalid  in  1  beat valid.
- S_AXIS_DATA_tready  out  1  beat accepted when tvalid&&tready; registered.
- o_Vector  out  BUS_WIDTH  beat to core.
- o_Valid  out  1  o_Vector valid.
- i_Read  in  1  core accepts when o_Valid&&i_Read.
- i_IDPair_Out  in  CH_NO*2*VEC_ID_WIDTH  per-channel pair; channel k occupies bits [k*2*VEC_ID_WIDTH +: 2*VEC_ID_WIDTH].
- i_IDPair_Ready  in  CH_NO  channel k holds a pair.
- o_IDPair_Read  out  CH_NO  one-hot grant; channel pops on this cycle's edge.
- M_AXIS_ID_PAIR_tdata  out  2*VEC_ID_WIDTH  pair output.
- M_AXIS_ID_PAIR_tvalid  out  1  FIFO non-empty.
- M_AXIS_ID_PAIR_tready  in  1  downstream accept.
- o_VecCount  out  CNT_WIDTH  accepted S_AXIS beats, saturating.
- o_PairCount  out  CNT_WIDTH  delivered M_AXIS pairs, saturating.

## Operation
- **Reset.** ap_rstn low clears all state asynchronously. In-flight beats and FIFO contents are discarded. The arbiter pointer goes to 0.
  - During reset, every output is 0: tready, o_Valid, o_Vector, o_IDPair_Read, tvalid, tdata, both counters.
- **Input skid.** Two-entry buffer (main + skid).
  - tready is registered; it is 1 exactly when the skid entry is empty.
  - o_Valid/o_Vector come from the main register.
  - A beat accepted while the main register is occupied and not being consumed goes to skid.
  - When main drains, skid moves to main on the same edge.
  - Order is preserved; no loss or duplication under any tvalid/i_Read pattern.
- **Arbiter.** Round-robin pointer ptr in 0..CH_NO-1.
  - Each cycle with fifo_count < FIFO_DEPTH, grant g = first index at or after ptr (wrapping) with i_IDPair_Ready[g]=1.
  - o_IDPair_Read[g] is high combinationally for that cycle; channel g's pair is pushed on that edge; ptr <= (g+1) mod CH_NO.
  - No grant leaves ptr unchanged.
  - The full test uses the registered count only: a same-cycle pop does not enable a push at full.
- **FIFO.** First-word-fall-through; binary pointers with count.
  - tvalid = (count != 0); tdata = head entry.
  - Pop on tvalid&&tready.
  - Simultaneous push and pop leaves count unchanged.
  - Push at empty becomes visible on tvalid the next cycle.
- **Counters.**
  - o_VecCount += 1 on each S_AXIS handshake.
  - o_PairCount += 1 on each M_AXIS handshake.
  - Both hold at 2^CNT_WIDTH-1.

## Timing
- S_AXIS accept to o_Valid: 1 cycle. Sustained throughput is 1 beat/cycle with i_Read=1.
- tready deasserts the cycle after skid fills; it reasserts the cycle after skid empties.
- Grant to M_AXIS_ID_PAIR_tvalid (empty FIFO): 1 cycle. Pair throughput is at most 1/cycle.
- M_AXIS tdata/tvalid are stable while tvalid=1 and tready=0.
- Counters update on the edge of the handshake and are visible the next cycle.
- After ap_rstn deasserts, tready rises on the first ap_clk edge.

## Test plan
- **Reset values.** Assert ap_rstn=0 mid-traffic with the FIFO holding 5 pairs → all outputs 0 immediately. After release: tready=1 one edge later, tvalid=0, counters 0, first grant goes to channel 0.
- **Input skid.** Drive 8 beats 0x1..0x8 with tvalid=1, and i_Read pattern 1,0,0,1,1,0,1,1… → o_Vector sequence is exactly 0x1..0x8. tready drops only while skid is full. o_VecCount=8.
- **Round-robin fairness.** CH_NO=4, all i_IDPair_Ready=1, tready=1 → grants 0,1,2,3,0,1 on consecutive cycles. Channel k holds pair value k, so M_AXIS emits 0,1,2,3,0,1 starting one cycle after the first grant.
- **Sparse ready.** Only channels 1 and 3 ready, with ptr=2 → grant 3, then 1, then 3.
- **Backpressure.** With tready=0 and all channels ready, the FIFO fills in 16 cycles; o_IDPair_Read is 0 from then on and tvalid=1 with head stable. With count=16, a pop alone must not allow a push that cycle. Raise tready → 16 pairs in grant order; o_PairCount=16.
- **Counter saturation.** CNT_WIDTH=3, send 10 beats → o_VecCount holds 7.

Source files
------------

// File: rtl/tanimoto_axis_intf.sv
// AXI-Stream shell for the Tanimoto comparator array: a zero-bubble skid buffer on the
// vector path, and round-robin pair collection into a FWFT FIFO with saturating status counters.
module tanimoto_axis_intf #(
    parameter int BUS_WIDTH    = 512,
    parameter int VEC_ID_WIDTH = 8,
    parameter int CH_NO        = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rstn,
    input  logic [BUS_WIDTH-1:0]            S_AXIS_DATA_tdata,
    input  logic                            S_AXIS_DATA_tvalid,
    output logic                            S_AXIS_DATA_tready,
    output logic [BUS_WIDTH-1:0]            o_Vector,
    output logic                            o_Valid,
    input  logic                            i_Read,
    input  logic [CH_NO*2*VEC_ID_WIDTH-1:0] i_IDPair_Out,
    input  logic [CH_NO-1:0]                i_IDPair_Ready,
    output logic [CH_NO-1:0]                o_IDPair_Read,
    output logic [2*VEC_ID_WIDTH-1:0]       M_AXIS_ID_PAIR_tdata,
    output logic                            M_AXIS_ID_PAIR_tvalid,
    input  logic                            M_AXIS_ID_PAIR_tready,
    output logic [CNT_WIDTH-1:0]            o_VecCount,
    output logic [CNT_WIDTH-1:0]            o_PairCount
);

    localparam int PAIR_W = 2 * VEC_ID_WIDTH;
    localparam int PTR_W  = (CH_NO > 1) ? $clog2(CH_NO) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = AW + 1;
    localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic                 vld;
        logic [BUS_WIDTH-1:0] data;
    } beat_t;

    // ---------------------------------------------------------------- input skid
    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  s_tready_q, s_tready_d;
    logic  s_accept;
    logic  core_take;

    always_comb begin
        main_d    = main_q;
        skid_d    = skid_q;
        s_accept  = S_AXIS_DATA_tvalid && s_tready_q;
        core_take = main_q.vld && i_Read;
        if (!main_q.vld || core_take) begin
            // skid is older than anything arriving now, so it always wins the refill
            if (skid_q.vld) begin
                main_d     = skid_q;
                skid_d.vld = 1'b0;
            end else if (s_accept) begin
                main_d = '{vld: 1'b1, data: S_AXIS_DATA_tdata};
            end else begin
                main_d.vld = 1'b0;
            end
        end else if (s_accept) begin
            skid_d = '{vld: 1'b1, data: S_AXIS_DATA_tdata};
        end
        s_tready_d = !skid_d.vld;
    end

    assign S_AXIS_DATA_tready = s_tready_q;
    assign o_Valid            = main_q.vld;
    assign o_Vector           = main_q.data;

    // ---------------------------------------------------------------- arbiter
    logic [CH_NO-1:0][PAIR_W-1:0] ch_pair;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [PTR_W-1:0]             gnt_idx;
    logic                         gnt_any;
    logic [CH_NO-1:0]             gnt_oh;
    logic [FCNT_W-1:0]            fcnt_q, fcnt_d;
    logic                         fifo_full;
    int                           scan_idx;

    assign ch_pair   = i_IDPair_Out;
    assign fifo_full = (fcnt_q == FIFO_FULL_CNT);

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_oh   = '0;
        scan_idx = 0;
        if (!fifo_full) begin
            for (int i = 0; i < CH_NO; i++) begin
                scan_idx = int'(ptr_q) + i;
                if (scan_idx >= CH_NO) scan_idx = scan_idx - CH_NO;
                if (!gnt_any && i_IDPair_Ready[PTR_W'(scan_idx)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PTR_W'(scan_idx);
                end
            end
        end
        if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (int'(gnt_idx) == CH_NO - 1) ? '0 : gnt_idx + 1'b1;
    end

    // grant is combinational, so it must be forced low while reset is held
    assign o_IDPair_Read = ap_rstn ? gnt_oh : '0;

    // ---------------------------------------------------------------- output FIFO
    logic [PAIR_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              push, pop;
    logic              m_tvalid;

    assign m_tvalid = (fcnt_q != '0);
    assign push     = gnt_any;
    assign pop      = m_tvalid && M_AXIS_ID_PAIR_tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (push) mem_q[wr_ptr_q] <= ch_pair[gnt_idx];
    end

    assign M_AXIS_ID_PAIR_tvalid = m_tvalid;
    assign M_AXIS_ID_PAIR_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;

    // ---------------------------------------------------------------- status counters
    logic [CNT_WIDTH-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_WIDTH-1:0] pair_cnt_q, pair_cnt_d;

    always_comb begin
        vec_cnt_d  = vec_cnt_q;
        pair_cnt_d = pair_cnt_q;
        if (s_accept && (vec_cnt_q != '1)) vec_cnt_d  = vec_cnt_q + 1'b1;
        if (pop && (pair_cnt_q != '1))     pair_cnt_d = pair_cnt_q + 1'b1;
    end

    assign o_VecCount  = vec_cnt_q;
    assign o_PairCount = pair_cnt_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            main_q     <= '0;
            skid_q     <= '0;
            s_tready_q <= 1'b0;
            ptr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            vec_cnt_q  <= '0;
            pair_cnt_q <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            s_tready_q <= s_tready_d;
            ptr_q      <= ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            vec_cnt_q  <= vec_cnt_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

endmodule

// File: tb/tb_tanimoto_axis_intf.sv
// Directed bench for tanimoto_axis_intf: table-driven skid checks plus hand-written
// arbiter, FIFO backpressure, reset and counter-saturation sequences.
module tb_tanimoto_axis_intf;

    logic         ap_clk = 1'b0;
    logic         ap_rstn;
    logic [511:0] s_tdata;
    logic         s_tvalid;
    logic         i_read;
    logic [63:0]  pair_out;
    logic [3:0]   pair_rdy;
    logic         m_tready;

    logic         s_tready, o_valid, m_tvalid;
    logic [511:0] o_vector;
    logic [3:0]   pair_read;
    logic [15:0]  m_tdata;
    logic [31:0]  vec_cnt, pair_cnt;

    logic         sat_tready, sat_valid, sat_m_tvalid;
    logic [511:0] sat_vector;
    logic [3:0]   sat_pair_read;
    logic [15:0]  sat_m_tdata;
    logic [2:0]   sat_vec_cnt, sat_pair_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 ap_clk = ~ap_clk;

    tanimoto_axis_intf dut (
        .ap_clk(ap_clk), .ap_rstn(ap_rstn),
        .S_AXIS_DATA_tdata(s_tdata), .S_AXIS_DATA_tvalid(s_tvalid), .S_AXIS_DATA_tready(s_tready),
        .o_Vector(o_vector), .o_Valid(o_valid), .i_Read(i_read),
        .i_IDPair_Out(pair_out), .i_IDPair_Ready(pair_rdy), .o_IDPair_Read(pair_read),
        .M_AXIS_ID_PAIR_tdata(m_tdata), .M_AXIS_ID_PAIR_tvalid(m_tvalid),
        .M_AXIS_ID_PAIR_tready(m_tready),
        .o_VecCount(vec_cnt), .o_PairCount(pair_cnt)
    );

    tanimoto_axis_intf #(.CNT_WIDTH(3)) dut_sat (
        .ap_clk(ap_clk), .ap_rstn(ap_rstn),
        .S_AXIS_DATA_tdata(s_tdata), .S_AXIS_DATA_tvalid(s_tvalid), .S_AXIS_DATA_tready(sat_tready),
        .o_Vector(sat_vector), .o_Valid(sat_valid), .i_Read(i_read),
        .i_IDPair_Out(pair_out), .i_IDPair_Ready(pair_rdy), .o_IDPair_Read(sat_pair_read),
        .M_AXIS_ID_PAIR_tdata(sat_m_tdata), .M_AXIS_ID_PAIR_tvalid(sat_m_tvalid),
        .M_AXIS_ID_PAIR_tready(m_tready),
        .o_VecCount(sat_vec_cnt), .o_PairCount(sat_pair_cnt)
    );

    typedef struct {
        logic        tv;
        logic [31:0] td;
        logic        rd;
        logic        exp_ov;
        logic [31:0] exp_vec;
        logic        exp_tr;
    } skid_vec_t;

    skid_vec_t sv [13];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_pairs(input logic [15:0] base);
        for (int k = 0; k < 4; k++) pair_out[k*16 +: 16] = base + 16'(k);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " tready"},    512'(s_tready),  '0);
        chk({tag, " o_Valid"},   512'(o_valid),   '0);
        chk({tag, " o_Vector"},  o_vector,        '0);
        chk({tag, " grant"},     512'(pair_read), '0);
        chk({tag, " m_tvalid"},  512'(m_tvalid),  '0);
        chk({tag, " m_tdata"},   512'(m_tdata),   '0);
        chk({tag, " vec_cnt"},   512'(vec_cnt),   '0);
        chk({tag, " pair_cnt"},  512'(pair_cnt),  '0);
        chk({tag, " sat outs"},
            512'({sat_tready, sat_valid, sat_m_tvalid, sat_pair_read, sat_m_tdata,
                  sat_vec_cnt, sat_pair_cnt}), '0);
        chk({tag, " sat vector"}, sat_vector, '0);
    endtask

    initial begin
        // tv, td, rd, exp_ov, exp_vec, exp_tr ; i_Read pattern 1,0,0,1,1,0,1,1,...
        sv[0]  = '{1'b1, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1};
        sv[1]  = '{1'b1, 32'd2, 1'b0, 1'b1, 32'd1, 1'b1};
        sv[2]  = '{1'b1, 32'd3, 1'b0, 1'b1, 32'd1, 1'b0};
        sv[3]  = '{1'b1, 32'd3, 1'b1, 1'b1, 32'd1, 1'b0};
        sv[4]  = '{1'b1, 32'd3, 1'b1, 1'b1, 32'd2, 1'b1};
        sv[5]  = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd3, 1'b1};
        sv[6]  = '{1'b1, 32'd5, 1'b1, 1'b1, 32'd3, 1'b0};
        sv[7]  = '{1'b1, 32'd5, 1'b1, 1'b1, 32'd4, 1'b1};
        sv[8]  = '{1'b1, 32'd6, 1'b1, 1'b1, 32'd5, 1'b1};
        sv[9]  = '{1'b1, 32'd7, 1'b1, 1'b1, 32'd6, 1'b1};
        sv[10] = '{1'b1, 32'd8, 1'b1, 1'b1, 32'd7, 1'b1};
        sv[11] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 1'b1};
        sv[12] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1};

        ap_rstn  = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        i_read   = 1'b0;
        pair_out = '0;
        pair_rdy = 4'hF;
        m_tready = 1'b0;

        // power-on reset
        #3;
        chk_reset_outputs("por");
        cyc();
        ap_rstn  = 1'b1;
        pair_rdy = 4'h0;
        #1;
        chk("tready before first edge", 512'(s_tready), '0);
        cyc();
        chk("tready after first edge", 512'(s_tready), 512'(1));

        // input skid
        for (int i = 0; i < 13; i++) begin
            s_tvalid = sv[i].tv;
            s_tdata  = 512'(sv[i].td);
            i_read   = sv[i].rd;
            #1;
            chk($sformatf("skid[%0d] o_Valid", i), 512'(o_valid), 512'(sv[i].exp_ov));
            if (sv[i].exp_ov) chk($sformatf("skid[%0d] o_Vector", i), o_vector, 512'(sv[i].exp_vec));
            chk($sformatf("skid[%0d] tready", i), 512'(s_tready), 512'(sv[i].exp_tr));
            cyc();
        end
        chk("vec_cnt after 8", 512'(vec_cnt), 512'(8));
        s_tvalid = 1'b1;
        s_tdata  = 512'(9);
        cyc();
        s_tdata  = 512'(10);
        cyc();
        s_tvalid = 1'b0;
        s_tdata  = '0;
        #1;
        chk("vec_cnt after 10", 512'(vec_cnt), 512'(10));
        chk("sat vec_cnt after 10", 512'(sat_vec_cnt), 512'(7));
        cyc();

        // round-robin, all channels ready, downstream always ready
        set_pairs(16'h0);
        pair_rdy = 4'hF;
        m_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr[%0d] grant", i), 512'(pair_read), 512'(4'b0001 << (i % 4)));
            chk($sformatf("rr[%0d] tvalid", i), 512'(m_tvalid), 512'(i > 0));
            if (i > 0) chk($sformatf("rr[%0d] tdata", i), 512'(m_tdata), 512'((i - 1) % 4));
            cyc();
        end
        pair_rdy = 4'h0;
        #1;
        chk("rr tail grant", 512'(pair_read), '0);
        chk("rr tail tdata", 512'(m_tdata), 512'(1));
        cyc();
        #1;
        chk("rr drained", 512'(m_tvalid), '0);
        chk("rr pair_cnt", 512'(pair_cnt), 512'(6));

        // sparse ready with pointer at 2
        pair_rdy = 4'b1010;
        for (int s = 0; s < 3; s++) begin
            logic [3:0] eg;
            eg = (s == 1) ? 4'b0010 : 4'b1000;
            #1;
            chk($sformatf("sparse[%0d] grant", s), 512'(pair_read), 512'(eg));
            chk($sformatf("sparse[%0d] tvalid", s), 512'(m_tvalid), 512'(s > 0));
            if (s > 0) chk($sformatf("sparse[%0d] tdata", s), 512'(m_tdata), 512'((s == 1) ? 3 : 1));
            cyc();
        end
        pair_rdy = 4'h0;
        #1;
        chk("sparse tail tdata", 512'(m_tdata), 512'(3));
        cyc();
        #1;
        chk("sparse pair_cnt", 512'(pair_cnt), 512'(9));

        // mid-traffic reset with 5 pairs queued and both skid entries full
        set_pairs(16'h20);
        pair_rdy = 4'hF;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 512'(32'hAA);
        i_read   = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        #1;
        chk("pre-reset tvalid", 512'(m_tvalid), 512'(1));
        chk("pre-reset head", 512'(m_tdata), 512'(16'h20));
        ap_rstn = 1'b0;
        #1;
        chk_reset_outputs("mid");
        cyc();
        chk("held reset grant", 512'(pair_read), '0);
        ap_rstn = 1'b1;
        #1;
        chk("release grant ch0", 512'(pair_read), 512'(4'b0001));
        chk("release tvalid", 512'(m_tvalid), '0);
        chk("release counters", 512'({vec_cnt, pair_cnt}), '0);
        pair_rdy = 4'h0;
        s_tvalid = 1'b0;
        cyc();
        chk("release tready", 512'(s_tready), 512'(1));

        // backpressure: fill 16 entries, then drain in grant order
        set_pairs(16'h10);
        pair_rdy = 4'hF;
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("fill[%0d] grant", i), 512'(pair_read), 512'(4'b0001 << (i % 4)));
            chk($sformatf("fill[%0d] tvalid", i), 512'(m_tvalid), 512'(i > 0));
            if (i > 0) chk($sformatf("fill[%0d] head", i), 512'(m_tdata), 512'(16'h10));
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("full grant", 512'(pair_read), '0);
            chk("full head", 512'({m_tvalid, m_tdata}), 512'({1'b1, 16'h10}));
            cyc();
        end
        m_tready = 1'b1;
        #1;
        chk("pop at full grant", 512'(pair_read), '0);
        chk("pop at full head", 512'(m_tdata), 512'(16'h10));
        cyc();
        pair_rdy = 4'h0;
        for (int j = 1; j < 16; j++) begin
            #1;
            chk($sformatf("drain[%0d]", j), 512'({m_tvalid, m_tdata}), 512'({1'b1, 16'h10 + 16'(j % 4)}));
            cyc();
        end
        #1;
        chk("drain empty", 512'(m_tvalid), '0);
        chk("drain pair_cnt", 512'(pair_cnt), 512'(16));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
